clock_period_meter: RTL and testbench

//   Measures the period of a slow, asynchronous square wave (e.g. a divided clock)
//   in cycles of clk_in. Checking counterpart to the clock divider: it consumes a divided clock.

---
 rtl/clk_meas_pkg.sv | 7 +
 rtl/clock_period_meter_edge_sync.sv | 27 ++
 rtl/clock_period_meter.sv | 96 +++++++++
 tb/tb_clock_period_meter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared state type and default sizing for the clock period meter
package clk_meas_pkg;
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam int CNT_W_DEF = 32;
  localparam int TIMEOUT_DEF = 100000;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/clock_period_meter_edge_sync.sv
// edge_sync: synchronises an asynchronous input and flags its rising/falling edges
// ports: clk_in, rst (async, active-high), d (async in), s (synchronised level), rise/fall (1-cycle pulses)
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sr;
  logic s_d;
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      s_d <= 1'b0;
    end else begin
      sr  <= {sr[SYNC_STAGES-2:0], d};
      s_d <= sr[SYNC_STAGES-1];
    end
  end
  assign s    = sr[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
endmodule

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the period of a slow asynchronous square wave in clk_in cycles
// ports: clk_in, rst (async, active-high), sig_in (async), period/period_valid, locked, timeout,
//        high_time (present only when HIGH_TIME_EN is defined)
module clock_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
`ifdef HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] high_time
`endif
);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic rise, meas, expire;
`ifdef HIGH_TIME_EN
  logic s, fall;
  logic [CNT_W-1:0] hi, hi_cap;
`endif
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in(clk_in),
    .rst(rst),
    .d(sig_in),
`ifdef HIGH_TIME_EN
    .s(s),
    .rise(rise),
    .fall(fall)
`else
    .s(),
    .rise(rise),
    .fall()
`endif
  );
  // a rise on the expiry cycle is a valid measurement, so rise takes priority
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    meas     = 1'b0;
    expire   = 1'b0;
    if (state == IDLE) begin
      state_nx = rise ? MEASURE : IDLE;
      cnt_nx   = rise ? ONE : '0;
    end else if (rise) begin
      meas   = 1'b1;
      cnt_nx = ONE;
    end else if (cnt == TO_M1) begin
      expire   = 1'b1;
      state_nx = IDLE;
    end else begin
      cnt_nx = cnt + ONE;
    end
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      period_valid <= meas;
      timeout      <= expire;
      locked       <= meas ? 1'b1 : expire ? 1'b0 : locked;
      if (meas) period <= cnt;
    end
  end
`ifdef HIGH_TIME_EN
  // hi counts synchronised-high cycles since the last rise; captured at fall, published at next rise
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hi        <= '0;
      hi_cap    <= '0;
      high_time <= '0;
    end else begin
      hi <= rise ? ONE : (s && hi != TO_M1) ? hi + ONE : hi;
      if (fall) hi_cap <= hi;
      if (meas) high_time <= hi_cap;
    end
  end
`endif
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: randomized scoreboard bench for clock_period_meter against a sampled-edge model
module tb_clock_period_meter;
  import clk_meas_pkg::*;
  localparam int CW = 16;
  localparam int TO = 50;
  localparam int S  = 2;
  typedef struct {
    bit is_to;
    int cycle;
    int per;
    int hi;
  } ev_t;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic [CW-1:0] period;
  logic period_valid, locked, timeout;
  logic [CW-1:0] ht;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  ev_t q[$];
  clock_period_meter #(.CNT_W(CW), .TIMEOUT(TO), .SYNC_STAGES(S)) dut (
    .clk_in(clk_in),
    .rst(rst),
    .sig_in(sig_in),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout)
`ifdef HIGH_TIME_EN
    ,
    .high_time(ht)
`endif
  );
`ifndef HIGH_TIME_EN
  assign ht = '0;
`endif
  always #5 clk_in = ~clk_in;
  // reference model: works on the sig_in values sampled at each clk_in edge; every
  // decision surfaces S cycles later through the synchroniser
  initial begin
    bit prev, armed, v;
    int t_last, hi, hi_cap;
    prev = 0; armed = 0; t_last = 0; hi = 0; hi_cap = 0;
    forever begin
      @(posedge clk_in or posedge rst);
      if (rst) begin
        q.delete();
        prev = 0; armed = 0; hi = 0; hi_cap = 0;
      end else begin
        cyc++;
        v = sig_in;
        if (v && !prev) begin
          hi = 1;
          if (armed) q.push_back('{1'b0, cyc + S, cyc - t_last, hi_cap});
          armed = 1;
          t_last = cyc;
        end else begin
          if (v && hi < TO - 1) hi++;
          if (!v && prev) hi_cap = hi;
          if (armed && cyc - t_last == TO - 1) begin
            q.push_back('{1'b1, cyc + S, 0, 0});
            armed = 0;
          end
        end
        prev = v;
      end
    end
  end
  initial begin
    ev_t e;
    bit exp_locked;
    int exp_period;
    exp_locked = 0; exp_period = 0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        exp_locked = 0; exp_period = 0;
        checks++;
        if (period != 0 || period_valid || locked || timeout || ht != 0) begin
          errors++;
          $display("FAIL reset_state: period=%0d pv=%0b locked=%0b timeout=%0b high_time=%0d, required all 0",
                   period, period_valid, locked, timeout, ht);
        end
      end else begin
        while (q.size() != 0 && q[0].cycle < cyc) begin
          e = q.pop_front();
          checks++; errors++;
          $display("FAIL missed_event: no %s pulse at cycle %0d, required one", e.is_to ? "timeout" : "period_valid", e.cycle);
          exp_locked = !e.is_to;
          if (!e.is_to) exp_period = e.per;
        end
        if (period_valid || timeout) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: pv=%0b timeout=%0b at cycle %0d, required none", period_valid, timeout, cyc);
          end else begin
            e = q.pop_front();
            if (e.cycle != cyc || e.is_to != timeout || period_valid == timeout) begin
              errors++;
              $display("FAIL event_kind: pv=%0b timeout=%0b at cycle %0d, required %s at cycle %0d",
                       period_valid, timeout, cyc, e.is_to ? "timeout" : "period_valid", e.cycle);
            end else if (!e.is_to) begin
              checks++;
              if (period != CW'(e.per)) begin
                errors++;
                $display("FAIL period: got %0d, required %0d at cycle %0d", period, e.per, cyc);
              end
`ifdef HIGH_TIME_EN
              checks++;
              if (ht != CW'(e.hi)) begin
                errors++;
                $display("FAIL high_time: got %0d, required %0d at cycle %0d", ht, e.hi, cyc);
              end
`endif
            end else begin
              checks++;
              if (period != CW'(exp_period)) begin
                errors++;
                $display("FAIL period_hold: got %0d, required %0d after timeout", period, exp_period);
              end
            end
            exp_locked = !e.is_to;
            if (!e.is_to) exp_period = e.per;
          end
        end
        checks++;
        if (locked !== exp_locked) begin
          errors++;
          $display("FAIL locked: got %0b, required %0b at cycle %0d", locked, exp_locked, cyc);
        end
      end
    end
  end
  task automatic hold(input bit v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk_in);
    #2;
  endtask
  task automatic sq(input int h, input int l, input int k);
    repeat (k) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask
  task automatic pulse_rst(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk_in);
    #2;
    rst = 1'b0;
  endtask
  initial begin
    int h, l;
    pulse_rst(3);
    sq(5, 5, 6);
    hold(1'b0, 70);
    sq(5, 5, 4);
    hold(1'b0, 70);
    hold(1'b1, 3);
    hold(1'b0, 70);
    sq(10, TO - 1 - 10, 2);
    hold(1'b1, 10);
    hold(1'b0, TO - 10);
    hold(1'b1, 10);
    hold(1'b0, 70);
    sq(5, 5, 3);
    hold(1'b1, 3);
    pulse_rst(3);
    hold(1'b1, 2);
    hold(1'b0, 5);
    sq(5, 5, 3);
    sq(MIN_PERIOD / 2, MIN_PERIOD / 2, 20);
    repeat (60) begin
      h = $urandom_range(1, 12);
      l = $urandom_range(1, 12);
      if ($urandom_range(0, 9) == 0) l = $urandom_range(45, 60);
      if ($urandom_range(0, 9) == 0) h = $urandom_range(45, 60);
      sq(h, l, 1);
    end
    hold(1'b0, 70);
    @(negedge clk_in);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events outstanding, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
